// File: rtl/decode_cycle.sv
// decode_cycle: RV64I-subset decode stage. It decodes the instruction, reads the
// 32x64 register file and loads the ID/EX pipeline register.
// Optional macro DECODE_RF_BYPASS_EN: when defined, a register read in the same
// cycle as a writeback to that register returns the writeback data (write-first).
module decode_cycle #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  input  logic            StallE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  logic            reg_write, mem_write, branch, jump, alu_src;
  logic [1:0]      result_src;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1, rd2;

  logic [XLEN-1:0] regs [0:31];

  assign opcode    = InstrD[6:0];
  assign rd        = InstrD[11:7];
  assign funct3    = InstrD[14:12];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];
  assign funct7_b5 = InstrD[30];

  assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  assign imm_u = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};

  // alt selects the sub/sra variant; sltu shares the slt encoding
  function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Main decoder: control bits and immediate; unknown opcodes decode to a bubble
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    alu_ctl    = ALU_ADD;
    imm_ext    = '0;
    case (opcode)
      OPC_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_ext    = imm_i;
      end
      OPC_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = imm_s;
      end
      OPC_OPIMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = imm_i;
        // bit 30 is part of the immediate except for srai
        alu_ctl   = alu_arith(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_ctl   = alu_arith(funct3, funct7_b5);
      end
      OPC_BRANCH: begin
        branch  = 1'b1;
        alu_ctl = ALU_SUB;
        imm_ext = imm_b;
      end
      OPC_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_ext    = imm_j;
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = imm_u;
      end
      default: ;
    endcase
  end

  // Register file read ports; x0 is hard-wired to zero
  always_comb begin
    rd1 = regs[Rs1D];
    rd2 = regs[Rs2D];
`ifdef DECODE_RF_BYPASS_EN
    if (RegWriteW && (RDW == Rs1D)) rd1 = ResultW;
    if (RegWriteW && (RDW == Rs2D)) rd2 = ResultW;
`endif
    if (Rs1D == 5'd0) rd1 = '0;
    if (Rs2D == 5'd0) rd2 = '0;
  end

  // Register file write port; reset wins over a same-cycle writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWriteW && (RDW != 5'd0)) begin
      regs[RDW] <= ResultW;
    end
  end

  // ID/EX pipeline register: reset/flush clear, stall holds, otherwise load
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 4'b0000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RdE         <= 5'd0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
    end else if (!StallE) begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      BranchE     <= branch;
      JumpE       <= jump;
      ALUSrcE     <= alu_src;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_ctl;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RdE         <= rd;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed test-plan steps followed by random instructions,
// writebacks, flushes, stalls and resets, checked against a behavioural model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [63:0] ResultW;
  logic        FlushE, StallE;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [63:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .FlushE(FlushE), .StallE(StallE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, br, jp, as;
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic [63:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic        imm_chk;
  } ex_t;

  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  logic [63:0] mrf [32];
  ex_t         exp_e;
  // ALU code by funct3 for the non-alternate form (add, sll, slt, sltu->slt, xor, srl, or, and)
  logic [3:0]  alu_tbl [8] = '{4'd0, 4'd6, 4'd5, 4'd5, 4'd4, 4'd7, 4'd3, 4'd2};
  logic [6:0]  ops [9] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
                           7'b1101111, 7'b0110111, 7'b1100111, 7'b0010111};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL step %0d %s observed=%h expected=%h", step_no, tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] sext(input longint unsigned v, input int bits);
    longint s;
    s = longint'(v << (64 - bits));
    return 64'(s >>> (64 - bits));
  endfunction

  function automatic ex_t zero_ex();
    ex_t e = '{default: '0};
    e.imm_chk = 1'b1;
    return e;
  endfunction

  function automatic ex_t model_decode(input logic [31:0] ins, input logic [63:0] pc,
                                       input logic [63:0] a, input logic [63:0] b);
    ex_t e = zero_ex();
    logic [2:0] f3 = ins[14:12];
    logic       alt = ins[30];
    e.rd1 = a; e.rd2 = b; e.pc = pc; e.pc4 = pc + 64'd4;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    case (ins[6:0])
      7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = sext(ins[31:20], 12); end
      7'b0100011: begin e.mw = 1; e.as = 1; e.imm = sext({ins[31:25], ins[11:7]}, 12); end
      7'b0010011: begin
        e.rw = 1; e.as = 1; e.imm = sext(ins[31:20], 12);
        e.alu = (alt && f3 == 3'd5) ? 4'd8 : alu_tbl[f3];
      end
      7'b0110011: begin
        e.rw = 1;
        e.alu = (alt && f3 == 3'd0) ? 4'd1 : (alt && f3 == 3'd5) ? 4'd8 : alu_tbl[f3];
      end
      7'b1100011: begin
        e.br = 1; e.alu = 4'd1;
        e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      end
      7'b1101111: begin
        e.rw = 1; e.jp = 1; e.rs = 2'b10;
        e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      7'b0110111: begin e.rw = 1; e.as = 1; e.imm = sext({ins[31:12], 12'h000}, 32); end
      default: e.imm_chk = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] r, input logic wen,
                                             input logic [4:0] wa, input logic [63:0] wd);
    if (r == 5'd0) return 64'd0;
`ifdef DECODE_RF_BYPASS_EN
    if (wen && wa == r) return wd;
`endif
    return mrf[r];
  endfunction

  task automatic compare_all();
    chk("RegWriteE", RegWriteE, exp_e.rw);
    chk("MemWriteE", MemWriteE, exp_e.mw);
    chk("BranchE", BranchE, exp_e.br);
    chk("JumpE", JumpE, exp_e.jp);
    chk("ALUSrcE", ALUSrcE, exp_e.as);
    chk("ResultSrcE", ResultSrcE, exp_e.rs);
    chk("ALUControlE", ALUControlE, exp_e.alu);
    chk("RD1E", RD1E, exp_e.rd1);
    chk("RD2E", RD2E, exp_e.rd2);
    if (exp_e.imm_chk) chk("ImmExtE", ImmExtE, exp_e.imm);
    chk("PCE", PCE, exp_e.pc);
    chk("PCPlus4E", PCPlus4E, exp_e.pc4);
    chk("RdE", RdE, exp_e.rd);
    chk("Rs1E", Rs1E, exp_e.rs1);
    chk("Rs2E", Rs2E, exp_e.rs2);
  endtask

  // One clock: drive inputs, check the combinational source fields, predict, clock, compare
  task automatic step(input logic [31:0] ins, input logic [63:0] pc, input logic wen,
                      input logic [4:0] wa, input logic [63:0] wd,
                      input logic fl, input logic st, input logic r);
    ex_t dec;
    step_no++;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 64'd4;
    RegWriteW = wen; RDW = wa; ResultW = wd;
    FlushE = fl; StallE = st; rst = r;
    #1;
    chk("Rs1D", Rs1D, ins[19:15]);
    chk("Rs2D", Rs2D, ins[24:20]);
    dec = model_decode(ins, pc, model_read(ins[19:15], wen, wa, wd),
                       model_read(ins[24:20], wen, wa, wd));
    if (r || fl) exp_e = zero_ex();
    else if (!st) exp_e = dec;
    if (r) for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
    else if (wen && wa != 5'd0) mrf[wa] = wd;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  initial begin
    logic [31:0] ins;
    logic [4:0]  wa;
    exp_e = zero_ex();
    for (int i = 0; i < 32; i++) mrf[i] = 64'd0;

    // reset for one cycle, then a zero instruction leaves every E output 0
    step(32'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("zero_pce", PCE, 64'h0);
    for (int i = 1; i < 32; i++) begin
      step(mk_add(5'd0, 5'(i), 5'(32 - i)), 64'h100, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk("rst_rd1", RD1E, 64'h0);
    end

    // writebacks then add x3,x1,x2
    step(32'h0, 64'h0, 1'b1, 5'd1, 64'd5, 1'b0, 1'b0, 1'b0);
    step(32'h0, 64'h0, 1'b1, 5'd2, 64'd7, 1'b0, 1'b0, 1'b0);
    step(32'h002081B3, 64'h200, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("add_rd1", RD1E, 64'd5);
    chk("add_rd2", RD2E, 64'd7);
    chk("add_rd", RdE, 64'd3);
    chk("add_rw", RegWriteE, 64'd1);
    chk("add_alu", ALUControlE, 64'd0);
    chk("add_alusrc", ALUSrcE, 64'd0);

    // sd x2,8(x1) and beq x1,x2,-4
    step(32'h0020B423, 64'h204, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("sd_mw", MemWriteE, 64'd1);
    chk("sd_rw", RegWriteE, 64'd0);
    chk("sd_alusrc", ALUSrcE, 64'd1);
    chk("sd_imm", ImmExtE, 64'd8);
    step(32'hFE208EE3, 64'h208, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("beq_br", BranchE, 64'd1);
    chk("beq_alu", ALUControlE, 64'd1);
    chk("beq_imm", ImmExtE, 64'hFFFF_FFFF_FFFF_FFFC);

    // write to x0 is dropped
    step(32'h0, 64'h0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    step(mk_add(5'd4, 5'd0, 5'd0), 64'h20C, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("x0_rd1", RD1E, 64'h0);

    // same-cycle write and read of x1
    step(mk_add(5'd5, 5'd1, 5'd2), 64'h210, 1'b1, 5'd1, 64'h99, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_RF_BYPASS_EN
    chk("bypass_rd1", RD1E, 64'h99);
`else
    chk("bypass_rd1", RD1E, 64'd5);
`endif

    // load, stall holds, flush+stall clears, stall holds the cleared state
    step(32'h002081B3, 64'h300, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(32'h0020B423, 64'h304, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("stall_rd", RdE, 64'd3);
    chk("stall_pc", PCE, 64'h300);
    step(32'h002081B3, 64'h308, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 1'b0);
    chk("flush_rw", RegWriteE, 64'd0);
    chk("flush_rd1", RD1E, 64'd0);
    step(32'h002081B3, 64'h30C, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("held_rd", RdE, 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      wa = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
      step(ins, {$urandom, $urandom}, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
